// File: rtl/ddr2_cmd_arbiter_pkg.sv
// Shared types and helpers for the DDR2 command-bus arbiter.
// Command encodings, arbiter FSM states and block-write length decode.
package ddr2_cmd_arbiter_pkg;

  localparam int unsigned CmdW  = 3;
  localparam int unsigned SzW   = 2;
  localparam int unsigned OpW   = 3;
  localparam int unsigned AddrW = 25;
  localparam int unsigned DataW = 16;
  localparam int unsigned BeatW = 6;

  typedef enum logic [CmdW-1:0] {
    CmdNop   = 3'd0,
    CmdScRd  = 3'd1,
    CmdScWr  = 3'd2,
    CmdBlkRd = 3'd3,
    CmdBlkWr = 3'd4,
    CmdAtRd  = 3'd5,
    CmdAtWr  = 3'd6,
    CmdNop7  = 3'd7
  } ddr2_cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBlkwr
  } arb_state_e;

  // Block-write length in words: 4, 8, 16 or 32.
  function automatic logic [BeatW-1:0] blk_words(input logic [SzW-1:0] sz);
    return BeatW'(4) << sz;
  endfunction

endpackage

// File: rtl/ddr2_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward (with wrap)
// from the slot after ptr.
module ddr2_cmd_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_valid
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  int unsigned idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    // Scan from the farthest slot down so the nearest requester overwrites last.
    for (int off = int'(NUM_REQ); off >= 1; off--) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (req[IdxW'(idx)]) begin
        winner    = IdxW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// Round-robin arbiter sharing the DDR2 controller command bus among NUM_REQ requesters.
// Defining DDR2_ARB_WATCHDOG_EN adds a block-write fetch timeout (wdog_err).
module ddr2_cmd_arbiter
  import ddr2_cmd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [3*NUM_REQ-1:0]         req_cmd,
  input  logic [2*NUM_REQ-1:0]         req_sz,
  input  logic [3*NUM_REQ-1:0]         req_op,
  input  logic [25*NUM_REQ-1:0]        req_addr,
  input  logic [16*NUM_REQ-1:0]        req_din,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           req_data_pop,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  input  logic                         ready,
  input  logic                         fetching,
  output logic [2:0]                   cmd,
  output logic [1:0]                   sz,
  output logic [2:0]                   op,
  output logic [24:0]                  addr,
  output logic [15:0]                  din,
  output logic                         wdog_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [CmdW-1:0]  cmd_arr  [NUM_REQ];
  logic [SzW-1:0]   sz_arr   [NUM_REQ];
  logic [OpW-1:0]   op_arr   [NUM_REQ];
  logic [AddrW-1:0] addr_arr [NUM_REQ];
  logic [DataW-1:0] din_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign cmd_arr[i]  = req_cmd[CmdW*i +: CmdW];
    assign sz_arr[i]   = req_sz[SzW*i +: SzW];
    assign op_arr[i]   = req_op[OpW*i +: OpW];
    assign addr_arr[i] = req_addr[AddrW*i +: AddrW];
    assign din_arr[i]  = req_din[DataW*i +: DataW];
  end

  arb_state_e       state_q, state_d;
  logic [CmdW-1:0]  cmd_q, cmd_d;
  logic [SzW-1:0]   sz_q, sz_d;
  logic [OpW-1:0]   op_q, op_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [IdxW-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [BeatW-1:0] beats_q, beats_d;

  logic [IdxW-1:0]  winner;
  logic             any_valid;
  logic             accept;

  ddr2_cmd_arbiter_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr_q),
    .winner   (winner),
    .any_valid(any_valid)
  );

`ifdef DDR2_ARB_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_LIMIT + 1);
  logic [WdogW-1:0] idle_q, idle_d;
  logic             wdog_err_q, wdog_err_d;
`endif

  // NOP encodings are acknowledged without waiting for the controller.
  assign accept = ready || (cmd_q == CmdNop) || (cmd_q == CmdNop7);

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    sz_d         = sz_q;
    op_d         = op_q;
    addr_d       = addr_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    beats_d      = beats_q;
    req_ready    = '0;
    req_data_pop = '0;
    din          = '0;
`ifdef DDR2_ARB_WATCHDOG_EN
    idle_d       = '0;
    wdog_err_d   = wdog_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          cmd_d   = cmd_arr[winner];
          sz_d    = sz_arr[winner];
          op_d    = op_arr[winner];
          addr_d  = addr_arr[winner];
          grant_d = winner;
          ptr_d   = winner;
          state_d = StIssue;
        end
      end
      StIssue: begin
        din = din_arr[grant_q];
        if (accept) begin
          req_ready[grant_q] = !reset;
          cmd_d              = CmdNop;
          if (cmd_q == CmdBlkWr) begin
            beats_d = blk_words(sz_q);
            state_d = StBlkwr;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBlkwr: begin
        din = din_arr[grant_q];
        if (fetching) begin
          req_data_pop[grant_q] = !reset;
          beats_d               = beats_q - BeatW'(1);
          if (beats_q == BeatW'(1)) begin
            state_d = StIdle;
          end
        end
`ifdef DDR2_ARB_WATCHDOG_EN
        else begin
          idle_d = idle_q + 1'b1;
          // Remaining beats are abandoned; the requester sees no further pops.
          if (idle_d == WdogW'(WDOG_LIMIT)) begin
            wdog_err_d = 1'b1;
            state_d    = StIdle;
          end
        end
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      sz_q    <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      grant_q <= '0;
      ptr_q   <= IdxW'(NUM_REQ - 1);
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sz_q    <= sz_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
    end
  end

`ifdef DDR2_ARB_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      idle_q     <= idle_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WDOG_LIMIT;
  assign wdog_err          = 1'b0;
`endif

  assign cmd      = cmd_q;
  assign sz       = sz_q;
  assign op       = op_q;
  assign addr     = addr_q;
  assign grant_id = grant_q;

endmodule

// File: doc/ddr2_cmd_arbiter.md
Name: ddr2_cmd_arbiter

Overview:
Shares the single DDR2-controller command bus (cmd/sz/op/addr/din, with fetching back) between NUM_REQ requesters using round-robin arbitration.
Sequences each granted command: it holds the command until the controller accepts it, then streams block-write data beats under control of fetching.
Sits between the stimulus drivers/requesters and the DDR2 controller, upstream of the command monitor.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WDOG_LIMIT, 255, max cycles without fetching during a block write (used only with the optional feature)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high
req_valid  input  NUM_REQ  per-requester command pending
req_cmd  input  3*NUM_REQ  per-requester cmd, slice i = [3i+2:3i]
req_sz  input  2*NUM_REQ  per-requester size
req_op  input  3*NUM_REQ  per-requester atomic op
req_addr  input  25*NUM_REQ  per-requester address
req_din  input  16*NUM_REQ  per-requester write data / current block-write word
req_ready  output  NUM_REQ  one-cycle pulse: requester's command accepted
req_data_pop  output  NUM_REQ  one-cycle pulse: current block-write word consumed, present next word
grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester
ready  input  1  controller can accept a command this cycle
fetching  input  1  controller samples din this cycle during a block write
cmd  output  3  to controller
sz  output  2  to controller
op  output  3  to controller
addr  output  25  to controller
din  output  16  to controller
wdog_err  output  1  sticky block-write timeout flag

Behaviour:
- Command encoding:
  - 0 NOP, 1 scalar read, 2 scalar write, 3 block read, 4 block write, 5 atomic read, 6 atomic write, 7 NOP.
- Reset (synchronous):
  - state IDLE.
  - cmd/sz/op/addr/din = 0; req_ready = 0; req_data_pop = 0; grant_id = 0; wdog_err = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation abandons any in-flight command or block write without completing it.
- FSM states: IDLE, ISSUE, BLKWR.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning upward (with wrap) from pointer+1.
  - On that edge, register the winner's cmd/sz/op/addr onto the bus, set grant_id = winner, set pointer = winner, go to ISSUE.
  - No request: bus holds cmd = 0.
- ISSUE:
  - Bus fields are held stable.
  - req_ready[grant_id] = ready (combinational). The cycle with ready=1 is the acceptance cycle T.
  - If cmd = 0 or 7: req_ready pulses in the first ISSUE cycle regardless of ready.
  - At T, cmd = 4: go to BLKWR, load beat counter = 4<<sz (4/8/16/32 words). The first beat can occur at T+1.
  - Otherwise: go to IDLE.
  - Earliest next command appears on the bus at T+2.
- BLKWR:
  - cmd output is 0 (NOP); sz/op/addr are held.
  - Each cycle with fetching=1: req_data_pop[grant_id] = 1 (combinational) and the counter decrements.
  - When the last word is fetched, go to IDLE on that edge.
  - fetching outside BLKWR is ignored.
- din:
  - Combinational mux of req_din[grant_id] in ISSUE and BLKWR; 0 in IDLE.
  - The requester must advance its word the cycle after req_data_pop.
- Requester rules:
  - Hold req_valid and all fields stable until req_ready.
  - If req_valid drops while in ISSUE, the latched command is still issued.
  - A requester re-asserting valid immediately after its own accept gets lowest priority against other pending requesters.
- Simultaneous events:
  - reset overrides everything.
  - Acceptance and a new req_valid from the same requester in the same cycle: the new request is arbitrated normally in the following IDLE cycle.
- The one-hot invariant holds: req_ready and req_data_pop are never both set and never set for more than one requester.

Optional Feature:
Macro: DDR2_ARB_WATCHDOG_EN
- Defined:
  - In BLKWR, an idle counter resets on each fetching and increments otherwise.
  - On reaching WDOG_LIMIT: set wdog_err (sticky until reset), drop to IDLE, discard remaining beats; no req_data_pop for them.
- Not defined: no counter; wdog_err tied 0; BLKWR waits indefinitely.

Decomposition:
- Add to definitions.sv:
  - ddr2_cmd_e enum for the 8 encodings.
  - arb_state_e enum (IDLE/ISSUE/BLKWR).
  - blk_words(sz) function returning 4<<sz.
- One sub-module: rr_arbiter (parameter NUM_REQ). Inputs: request vector, pointer. Outputs: winner index and any-valid flag. Combinational.

Test Plan:
- Reset, then req_valid=4'b0001 with cmd=1, addr=25'h0001008, ready=1 -> bus shows cmd=1 addr=25'h0001008 one cycle after the request; req_ready[0] pulse; grant_id=0.
- req_valid=4'b1111 held, all scalar writes, ready=1 -> grants in order 0,1,2,3,0; each command is 2 cycles apart after its predecessor's accept.
- Req 2 block write sz=1, ready=1, fetching high for 8 cycles -> 8 req_data_pop[2] pulses, din follows req_din[2], cmd=0 during the beats, IDLE after the 8th.
- Req 1 cmd=5 op=3 with ready low for 5 cycles -> bus held stable 5 cycles; req_ready[1] in the cycle ready rises.
- Reset asserted mid block write (after 3 of 16 beats) -> next edge: IDLE, all outputs 0, no further req_data_pop.
- With DDR2_ARB_WATCHDOG_EN and WDOG_LIMIT=10: block write, fetching stops after 2 beats -> wdog_err=1 after 10 idle cycles, returns to IDLE, stays high until reset.
